stopwatch_mmss: RTL and testbench
=================================

# stopwatch_mmss

Minutes/seconds stopwatch that consumes the slow square wave from the frequency divider (one rising edge per second at the standard divider setting). It counts seconds 00:00–59:59 in BCD under start/stop/clear control and drives four seven-segment digits directly. It sits between the divider and the board display/LED pins.

## Interface
- SEG_ACTIVE_LOW, default 1: 1 = segment lit when bit is 0 (board default); 0 = active-high.
- clk  in  1  system clock; same domain as the divider.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- slow_in  in  1  divider square-wave output. Each rising edge is one count tick.
- start_stop  in  1  debounced button level. Each rising edge toggles run/pause.
- clear  in  1  debounced button level. Each rising edge zeroes the count.
- sec_ones  out  4  BCD 0–9.
- sec_tens  out  4  BCD 0–5.
- min_ones  out  4  BCD 0–9.
- min_tens  out  4  BCD 0–5.
- hex0..hex3  out  7 each  segment patterns for sec_ones, sec_tens, min_ones, min_tens. Bit order {g,f,e,d,c,b,a}.
- running  out  1  high in RUNNING state.
- wrap  out  1  one-cycle pulse when the count rolls 59:59 → 00:00.

## Operation
- Edge detect:
  - Register slow_in, start_stop and clear once each (`*_q`).
  - tick = slow_in & ~slow_in_q. ss_edge and clr_edge are formed the same way.
  - All `*_q` registers reset to 0. A signal held high through reset therefore produces an edge on the first cycle after reset.
- FSM states: IDLE, RUNNING, PAUSED. Priority per cycle is clr_edge, then ss_edge.
  - clr_edge in any state: state → IDLE, all digits → 0.
  - IDLE + ss_edge → RUNNING.
  - RUNNING + ss_edge → PAUSED.
  - PAUSED + ss_edge → RUNNING.
- Counting: a tick increments the count only when the current (pre-edge) state is RUNNING and clr_edge is low.
  - Same cycle as ss_edge in RUNNING: the tick is counted and the state still goes to PAUSED.
  - Tick in IDLE or PAUSED: ignored, not remembered.
- BCD cascade:
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 carries into min_ones.
  - min_ones 9→0 carries into min_tens.
  - min_tens 5→0 with all lower digits rolling over asserts wrap for exactly that cycle's registered output.
- Digits never hold illegal BCD values: sec_tens and min_tens ≤ 5, ones digits ≤ 9.
- Segment decode is combinational from the digit registers.
  - Active-low patterns for 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - When SEG_ACTIVE_LOW=0, output the bitwise inverse.
- Reset mid-count: all state is lost; outputs return to reset values.

## Timing
- Reset values:
  - All digits 0; state IDLE; running=0; wrap=0.
  - hex0..3 = 1000000 (active-low "0").
  - Edge registers 0.
- Latency:
  - slow_in rises in cycle N (sampled at edge N): the new digit value and its hex pattern are visible from cycle N+1.
  - running changes in the cycle after the ss_edge sample.
  - wrap is high in cycle N+1 only.
- A single rising edge of slow_in is counted once, however long slow_in stays high.
- No handshake. Inputs must be synchronous to clk.

## Structure
- Package stopwatch_pkg contains:
  - the state enum typedef (IDLE, RUNNING, PAUSED);
  - a localparam array of the ten active-low segment patterns;
  - BCD limit constants (9, 5).
- Sub-module bcd_digit: one digit counter with parameter MAX, inputs inc and clr, outputs digit and carry (carry = inc && digit==MAX). Instantiate it four times in a chain.
- Edge detectors and the FSM stay in the top level.

## Test plan
- Reset, then 5 slow_in edges with no start press → digits stay 00:00, hex0..3 = 1000000, running=0.
- start_stop edge, then 10 ticks → sec_ones=0, sec_tens=1, hex1=1111001, running=1.
- Preload 59:58 by ticking while RUNNING, then 2 ticks → 59:59, then 00:00. wrap is high exactly one cycle, on the second tick.
- RUNNING at 00:07: start_stop edge and tick in the same cycle → 00:08 and PAUSED. 3 further ticks → still 00:08.
- PAUSED at 00:08: clear edge and tick in the same cycle → 00:00 and IDLE. Next start_stop edge → RUNNING from 00:00.
- SEG_ACTIVE_LOW=0 instance at count 08 → hex0=1111111, hex1=0111111.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch: FSM states, BCD limits
// and the active-low seven-segment table (bit order {g,f,e,d,c,b,a}).
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX_ONES = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS = 4'd5;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Non-BCD codes blank the digit; the counters never produce them.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] pat;
        pat = 7'b1111111;
        if (d <= BCD_MAX_ONES)
            pat = SEG_LUT[d];
        return pat;
    endfunction

endpackage

// File: rtl/stopwatch_mmss_bcd_digit.sv
// One BCD digit counter 0..MAX; digit updates one cycle after inc, carry is
// combinational (inc at MAX). No backpressure: inc is honoured every cycle.
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] r_digit;

    assign digit = r_digit;
    assign carry = inc && (r_digit == MAX);

    // >= rather than == so an out-of-range value can only ever roll to 0.
    always_ff @(posedge clk) begin
        if (rst || clr)
            r_digit <= 4'd0;
        else if (inc)
            r_digit <= (r_digit >= MAX) ? 4'd0 : r_digit + 4'd1;
    end

endmodule

// File: rtl/stopwatch_mmss.sv
// MM:SS BCD stopwatch counting slow_in rising edges under start/stop/clear;
// count, running and wrap register one cycle after the edge sample, no backpressure.
module stopwatch_mmss
    import stopwatch_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slow_in,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic       running,
    output logic       wrap
);

    logic   r_slow_q, r_ss_q, r_clr_q;
    logic   w_tick, w_ss_edge, w_clr_edge, w_inc;
    logic   w_c0, w_c1, w_c2, w_c3;
    state_t r_state;
    logic   r_running, r_wrap;

    // Edge registers reset to 0, so a level held through reset fires once after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slow_q <= 1'b0;
            r_ss_q   <= 1'b0;
            r_clr_q  <= 1'b0;
        end else begin
            r_slow_q <= slow_in;
            r_ss_q   <= start_stop;
            r_clr_q  <= clear;
        end
    end

    assign w_tick     = slow_in & ~r_slow_q;
    assign w_ss_edge  = start_stop & ~r_ss_q;
    assign w_clr_edge = clear & ~r_clr_q;
    assign w_inc      = w_tick && (r_state == RUNNING) && !w_clr_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
        end else if (w_clr_edge) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
        end else if (w_ss_edge) begin
            case (r_state)
                IDLE, PAUSED: begin
                    r_state   <= RUNNING;
                    r_running <= 1'b1;
                end
                RUNNING: begin
                    r_state   <= PAUSED;
                    r_running <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    bcd_digit #(.MAX(BCD_MAX_ONES)) u_sec_ones (
        .clk(clk), .rst(rst), .inc(w_inc), .clr(w_clr_edge), .digit(sec_ones), .carry(w_c0)
    );
    bcd_digit #(.MAX(BCD_MAX_TENS)) u_sec_tens (
        .clk(clk), .rst(rst), .inc(w_c0), .clr(w_clr_edge), .digit(sec_tens), .carry(w_c1)
    );
    bcd_digit #(.MAX(BCD_MAX_ONES)) u_min_ones (
        .clk(clk), .rst(rst), .inc(w_c1), .clr(w_clr_edge), .digit(min_ones), .carry(w_c2)
    );
    bcd_digit #(.MAX(BCD_MAX_TENS)) u_min_tens (
        .clk(clk), .rst(rst), .inc(w_c2), .clr(w_clr_edge), .digit(min_tens), .carry(w_c3)
    );

    // Carry out of the top digit means the whole count rolled 59:59 -> 00:00.
    always_ff @(posedge clk) begin
        if (rst)
            r_wrap <= 1'b0;
        else
            r_wrap <= w_c3;
    end

    assign running = r_running;
    assign wrap    = r_wrap;

    assign hex0 = SEG_ACTIVE_LOW ? seg_decode(sec_ones) : ~seg_decode(sec_ones);
    assign hex1 = SEG_ACTIVE_LOW ? seg_decode(sec_tens) : ~seg_decode(sec_tens);
    assign hex2 = SEG_ACTIVE_LOW ? seg_decode(min_ones) : ~seg_decode(min_ones);
    assign hex3 = SEG_ACTIVE_LOW ? seg_decode(min_tens) : ~seg_decode(min_tens);

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Directed bench for stopwatch_mmss: inputs change on negedge, outputs sampled on negedge.
module tb_stopwatch_mmss;

    logic       clk = 1'b0;
    logic       rst, slow_in, start_stop, clear;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic       running, wrap;
    logic [3:0] ah_so, ah_st, ah_mo, ah_mt;
    logic [6:0] ah_hex0, ah_hex1, ah_hex2, ah_hex3;
    logic       ah_running, ah_wrap;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    stopwatch_mmss dut (
        .clk(clk), .rst(rst), .slow_in(slow_in), .start_stop(start_stop), .clear(clear),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .running(running), .wrap(wrap)
    );

    stopwatch_mmss #(.SEG_ACTIVE_LOW(1'b0)) dut_ah (
        .clk(clk), .rst(rst), .slow_in(slow_in), .start_stop(start_stop), .clear(clear),
        .sec_ones(ah_so), .sec_tens(ah_st), .min_ones(ah_mo), .min_tens(ah_mt),
        .hex0(ah_hex0), .hex1(ah_hex1), .hex2(ah_hex2), .hex3(ah_hex3),
        .running(ah_running), .wrap(ah_wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_count(input string tag, input logic [15:0] exp);
        check(tag, {min_tens, min_ones, sec_tens, sec_ones}, exp);
    endtask

    task automatic tick();
        @(negedge clk) slow_in = 1'b1;
        @(negedge clk) slow_in = 1'b0;
    endtask

    task automatic press_ss();
        @(negedge clk) start_stop = 1'b1;
        @(negedge clk) start_stop = 1'b0;
    endtask

    logic wrap_seen;

    initial begin
        rst = 1'b1; slow_in = 1'b0; start_stop = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_count("reset_count", 16'h0000);
        check("reset_hex0", hex0, 7'b1000000);
        check("reset_hex3", hex3, 7'b1000000);
        check("reset_running", running, 1'b0);
        check("reset_wrap", wrap, 1'b0);

        // Ticks before any start press are ignored.
        repeat (5) tick();
        check_count("idle_count", 16'h0000);
        check("idle_hexes", {hex3, hex2, hex1, hex0}, {4{7'b1000000}});
        check("idle_running", running, 1'b0);

        press_ss();
        check("start_running", running, 1'b1);
        repeat (10) tick();
        check_count("ten_ticks", 16'h0010);
        check("ten_hex1", hex1, 7'b1111001);
        check("ten_hex0", hex0, 7'b1000000);

        // Preload 59:58 (3598 s total, 10 already counted).
        wrap_seen = 1'b0;
        for (int i = 0; i < 3588; i++) begin
            tick();
            wrap_seen = wrap_seen | wrap;
        end
        check_count("preload_5958", 16'h5958);
        check("preload_no_wrap", wrap_seen, 1'b0);
        tick();
        check_count("count_5959", 16'h5959);
        check("hex3_five", hex3, 7'b0010010);
        check("hex0_nine", hex0, 7'b0010000);
        check("no_wrap_5959", wrap, 1'b0);
        tick();
        check_count("rollover_0000", 16'h0000);
        check("wrap_pulse", wrap, 1'b1);
        @(negedge clk);
        check("wrap_one_cycle", wrap, 1'b0);

        repeat (7) tick();
        check_count("count_0007", 16'h0007);
        // start_stop edge and tick in the same cycle: tick counts, then pause.
        @(negedge clk) begin slow_in = 1'b1; start_stop = 1'b1; end
        @(negedge clk) begin slow_in = 1'b0; start_stop = 1'b0; end
        check_count("ss_tick_0008", 16'h0008);
        check("paused_running", running, 1'b0);
        check("al_hex0_eight", hex0, 7'b0000000);
        check("ah_hex0_eight", ah_hex0, 7'b1111111);
        check("ah_hex1_zero", ah_hex1, 7'b0111111);
        repeat (3) tick();
        check_count("paused_hold", 16'h0008);

        // clear edge and tick together in PAUSED.
        @(negedge clk) begin slow_in = 1'b1; clear = 1'b1; end
        @(negedge clk) begin slow_in = 1'b0; clear = 1'b0; end
        check_count("clear_0000", 16'h0000);
        check("clear_running", running, 1'b0);
        press_ss();
        check("restart_running", running, 1'b1);
        tick();
        check_count("restart_0001", 16'h0001);

        // slow_in held high for many cycles is a single tick.
        @(negedge clk) slow_in = 1'b1;
        repeat (6) @(negedge clk);
        slow_in = 1'b0;
        check_count("long_high_once", 16'h0002);

        // Reset mid-count, with start_stop held high through reset.
        @(negedge clk) begin rst = 1'b1; start_stop = 1'b1; end
        @(negedge clk) rst = 1'b0;
        check_count("midreset_count", 16'h0000);
        check("midreset_running", running, 1'b0);
        @(negedge clk);
        check("held_ss_edge", running, 1'b1);
        start_stop = 1'b0;
        tick();
        check_count("after_reset_tick", 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
